// File: rtl/hazard_if.sv
// hazard_if: groups the datapath-facing signals of hazard_ctrl_mc.
//   master : datapath side (drives register indices/controls, consumes stall/flush/forward)
//   slave  : hazard controller side
// Parameter REG_W sets the register index width.
interface hazard_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [2:0]       ResultSrcE;
  logic [1:0]       PCSrcE;
  logic             MduStartE;
  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MduBusy;
  logic [31:0]      StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MduStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MduBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MduStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MduBusy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: pipeline hazard controller for the 5-stage core with
// multi-cycle BRAM loads and a fixed-latency mul/div unit.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   hz         : hazard_if.slave (D/E/M/W register indices and controls in;
//                stall/flush/forward selects, MduBusy and perf counters out)
// Stall/flush/forward outputs are combinational: the datapath uses them in
// the same cycle. Optional macro HAZ_PERF_EN adds stall/redirect counters.
module hazard_ctrl_mc #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MDU_LAT  = 4,
  parameter logic [2:0]  RES_LOAD = 3'b100
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  hz
);

  localparam int unsigned MAX_LAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MDU_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;
  logic       redirect_c, ld_haz_c;
  logic [1:0] fwd_a, fwd_b;

  // Operand forwarding: M result beats W result; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (hz.RegWriteM && hz.Rs1E == hz.RdM && hz.Rs1E != REG_W'(0))      fwd_a = 2'b10;
      else if (hz.RegWriteW && hz.Rs1E == hz.RdW && hz.Rs1E != REG_W'(0)) fwd_a = 2'b01;
      if (hz.RegWriteM && hz.Rs2E == hz.RdM && hz.Rs2E != REG_W'(0))      fwd_b = 2'b10;
      else if (hz.RegWriteW && hz.Rs2E == hz.RdW && hz.Rs2E != REG_W'(0)) fwd_b = 2'b01;
    end
  end

  assign ld_haz_c = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != REG_W'(0)) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  // Next-state and stall/flush decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    redirect_c = 1'b0;
    if (reset) begin
      state_d = IDLE;
      cnt_d   = '0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.PCSrcE != 2'b00) begin
            // Redirect wins over a simultaneous load-use hazard.
            flush_d    = 1'b1;
            flush_e    = 1'b1;
            redirect_c = 1'b1;
          end else if (ld_haz_c) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end else if (hz.MduStartE && (MDU_LAT > 1)) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            state_d = MDU_BUSY;
            cnt_d   = CNT_W'(MDU_LAT - 2);
          end
        end
        LOAD_STALL: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        MDU_BUSY: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          // A zero count (MDU_LAT=2) still spends one cycle here.
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and count registers (reset handled in the next-state logic).
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushM    = flush_m;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.MduBusy   = (state_q == MDU_BUSY) && !reset;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running perf counters, wrap at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall_f);
    flush_cnt_d = flush_cnt_q + 32'(redirect_c);
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = 32'd0;
  assign hz.FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed self-checking bench for hazard_ctrl_mc
// (LOAD_LAT=2, MDU_LAT=4). Inputs change 1 time unit after posedge and
// outputs are checked 2 units later, well before the next edge.
module tb_hazard_ctrl_mc;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_if #(.REG_W(5)) hz ();

  hazard_ctrl_mc #(
    .REG_W(5), .LOAD_LAT(2), .MDU_LAT(4), .RES_LOAD(3'b100)
  ) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.ResultSrcE = 3'b000; hz.PCSrcE = 2'b00; hz.MduStartE = 1'b0;
  endtask

  // Packs {StallF,StallD,StallE,FlushD,FlushE,FlushM,MduBusy}.
  function automatic logic [6:0] ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.MduBusy};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    hz.ResultSrcE = 3'b100; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
    hz.RdM = 5'd3; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd3;
    step(); #1;
    checks++;
    if (ctl() !== 7'b0001110) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl(), 7'b0001110);
    end
    checks++;
    if (hz.ForwardAE !== 2'b00) begin
      failures++;
      $display("FAIL reset_fwd got=%b exp=00", hz.ForwardAE);
    end
    reset = 1'b0;
    clear_inputs();
    step(); #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL post_reset_ctl got=%b exp=0000000", ctl());
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hz.RdM = 5'd5; hz.RdW = 5'd5; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
    hz.Rs1E = 5'd5; hz.Rs2E = 5'd6;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b10) begin
      failures++;
      $display("FAIL fwd_m_prio got=%b exp=10", hz.ForwardAE);
    end
    checks++;
    if (hz.ForwardBE !== 2'b00) begin
      failures++;
      $display("FAIL fwd_b_nomatch got=%b exp=00", hz.ForwardBE);
    end
    hz.RegWriteM = 1'b0; hz.Rs2E = 5'd5;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b01) begin
      failures++;
      $display("FAIL fwd_w got=%b exp=01", hz.ForwardAE);
    end
    checks++;
    if (hz.ForwardBE !== 2'b01) begin
      failures++;
      $display("FAIL fwd_b_w got=%b exp=01", hz.ForwardBE);
    end
    hz.Rs1E = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0; hz.RegWriteM = 1'b1;
    #1;
    checks++;
    if (hz.ForwardAE !== 2'b00) begin
      failures++;
      $display("FAIL fwd_x0 got=%b exp=00", hz.ForwardAE);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.ResultSrcE = 3'b100; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1;
    checks++;
    if (ctl() !== 7'b1100100) begin
      failures++;
      $display("FAIL load_stall_c1 got=%b exp=1100100", ctl());
    end
    step(); #1;
    checks++;
    if (ctl() !== 7'b1100100) begin
      failures++;
      $display("FAIL load_stall_c2 got=%b exp=1100100", ctl());
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL load_release got=%b exp=0000000", ctl());
    end
    hz.ResultSrcE = 3'b100; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL load_x0 got=%b exp=0000000", ctl());
    end
    clear_inputs();
    step();
  endtask

  task automatic test_mdu();
    clear_inputs();
    hz.MduStartE = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b1110010) begin
      failures++;
      $display("FAIL mdu_c1 got=%b exp=1110010", ctl());
    end
    step();
    clear_inputs();
    hz.PCSrcE = 2'b01;
    #1;
    checks++;
    if (ctl() !== 7'b1110011) begin
      failures++;
      $display("FAIL mdu_c2 got=%b exp=1110011", ctl());
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== 7'b1110011) begin
      failures++;
      $display("FAIL mdu_c3 got=%b exp=1110011", ctl());
    end
    step(); #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL mdu_release got=%b exp=0000000", ctl());
    end
  endtask

  task automatic test_redirect();
    clear_inputs();
    hz.PCSrcE = 2'b01; hz.ResultSrcE = 3'b100; hz.RdE = 5'd9; hz.Rs1D = 5'd9;
    #1;
    checks++;
    if (ctl() !== 7'b0001100) begin
      failures++;
      $display("FAIL redirect_beats_load got=%b exp=0001100", ctl());
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL redirect_stays_idle got=%b exp=0000000", ctl());
    end
  endtask

  task automatic test_reset_mid_mdu();
    clear_inputs();
    hz.MduStartE = 1'b1;
    step();
    clear_inputs();
    #1;
    checks++;
    if (hz.MduBusy !== 1'b1) begin
      failures++;
      $display("FAIL mid_mdu_busy got=%b exp=1", hz.MduBusy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b0001110) begin
      failures++;
      $display("FAIL mid_mdu_in_reset got=%b exp=0001110", ctl());
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL mid_mdu_after_reset got=%b exp=0000000", ctl());
    end
    step(); #1;
    checks++;
    if (ctl() !== 7'b0000000) begin
      failures++;
      $display("FAIL mid_mdu_stays_idle got=%b exp=0000000", ctl());
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
`ifdef HAZ_PERF_EN
    exp_stall = 32'd3;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    do_reset();
    #1;
    checks++;
    if (hz.StallCnt !== 32'd0 || hz.FlushCnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", hz.StallCnt, hz.FlushCnt);
    end
    hz.MduStartE = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    hz.PCSrcE = 2'b10;
    step();
    hz.PCSrcE = 2'b01;
    step();
    clear_inputs();
    step(); #1;
    checks++;
    if (hz.StallCnt !== exp_stall) begin
      failures++;
      $display("FAIL perf_stall_cnt got=%0d exp=%0d", hz.StallCnt, exp_stall);
    end
    checks++;
    if (hz.FlushCnt !== exp_flush) begin
      failures++;
      $display("FAIL perf_flush_cnt got=%0d exp=%0d", hz.FlushCnt, exp_flush);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mdu();
    test_redirect();
    test_reset_mid_mdu();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
